// File: rtl/byte_stream_reader.sv
// Purpose: byte storage bank with a write port and a burst read engine that streams stored bytes out over valid/ready.
// Latency: first byte is valid the cycle after rd_start is sampled; one byte per cycle while out_ready stays high.
// Backpressure: out_valid && !out_ready holds the pointer and count, and rd_start is ignored while busy.
module byte_stream_reader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              store,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W:0]   rd_len,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_clamped;
    logic              xfer;

    // A burst never covers more than DEPTH bytes, so no entry is read twice.
    assign len_clamped = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;
    assign xfer        = out_valid && out_ready;

    // Storage bank: cleared on reset, written whenever store is high, regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (store) begin
            mem_q[wr_addr] <= data;
        end
    end

    // Read engine state, pointer and remaining-byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and outputs; the byte is read combinationally, so a same-edge write to ptr is seen only next cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_start) begin
                    ptr_d   = rd_addr;
                    cnt_d   = len_clamped;
                    state_d = (len_clamped == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[ptr_q];
                if (xfer) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (ADDR_W + 1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
